voice_mixer: RTL and testbench
==============================

Name: voice_mixer

Overview:
- Sample-rate mixing stage between the voice bank and the audio codec interface.
- On each rising edge of the DAC left/right clock, snapshots all voice outputs, per-voice gains and master volume.
- Serially multiply-accumulates one voice per cycle, applies master volume, saturates to 16 bits, and presents one signed sample with a single-cycle valid strobe to the codec data path.
- Replaces the truncating combinational voice sum.

Parameters:
- NUM_VOICES, 8, number of voice inputs (power of two, 2..16).
- SAMPLE_W, 16, signed sample width of each voice input and of the mixed output.
- GAIN_W, 8, unsigned width of per-voice gain and master volume; 2^GAIN_W-1 is near unity.

Ports:
- Clk  in  1  system clock (50 MHz).
- Reset_n  in  1  asynchronous active-low reset.
- lrck  in  1  DAC left/right clock; asynchronous to Clk.
- voice_in  in  NUM_VOICES*SAMPLE_W  signed voice samples; voice i at bits [i*SAMPLE_W +: SAMPLE_W].
- voice_gain  in  NUM_VOICES*GAIN_W  unsigned per-voice gain; voice i at [i*GAIN_W +: GAIN_W].
- voice_en  in  NUM_VOICES  per-voice enable (key_on); a disabled voice contributes 0.
- master_vol  in  GAIN_W  unsigned master volume.
- flag_clr  in  1  synchronous clear of the clip and overrun flags.
- mix_out  out  SAMPLE_W  signed mixed sample; held between updates.
- mix_valid  out  1  one-cycle pulse when mix_out updates.
- busy  out  1  high while not in IDLE.
- clip  out  1  sticky: an output sample saturated.
- overrun  out  1  sticky: an lrck edge arrived while busy.

Behaviour:
- Reset (asynchronous, Reset_n=0) clears all of the following:
  - Outputs: mix_out=0, mix_valid=0, busy=0, clip=0, overrun=0.
  - Internal: state=IDLE, sync regs=0, acc=0, idx=0.
- Edge detect:
  - lrck passes through a 2-FF synchronizer, then a previous-value register.
  - edge = sync & ~prev (one-cycle pulse).
- FSM: IDLE -> ACCUM -> SCALE -> OUT -> IDLE.
- IDLE:
  - On edge, register snapshots of voice_in, voice_gain, voice_en and master_vol into shadow registers.
  - Set acc=0, idx=0, then go to ACCUM.
  - Input changes after the capture cycle do not affect the sample in progress.
- ACCUM, one voice per cycle:
  - acc += voice_en[idx] ? voice_in[idx] * {0,voice_gain[idx]} : 0.
  - Product is signed, SAMPLE_W+GAIN_W bits.
  - acc width is SAMPLE_W+GAIN_W+log2(NUM_VOICES); no internal overflow is possible.
  - idx increments each cycle; after idx==NUM_VOICES-1, go to SCALE.
- SCALE:
  - prod = acc * {0,master_vol}, signed, full width.
  - Go to OUT.
- OUT:
  - s = prod >>> (2*GAIN_W), arithmetic shift, rounding toward -inf.
  - Saturate s to the SAMPLE_W signed range: >32767 -> 32767, <-32768 -> -32768.
  - Register the result to mix_out and pulse mix_valid.
  - If saturation occurred, set clip.
  - Return to IDLE.
- Latency, counting the cycle edge is high as cycle 0:
  - ACCUM occupies cycles 1..NUM_VOICES.
  - SCALE occupies cycle NUM_VOICES+1.
  - OUT occupies cycle NUM_VOICES+2.
  - mix_out/mix_valid are visible in cycle NUM_VOICES+3 (11 for the default).
- Edge while busy: ignored (no restart, no second sample) and overrun is set.
- Flag priority: if flag_clr and a set event occur in the same cycle, the set wins.
- busy is high in ACCUM, SCALE and OUT.
- Reset mid-operation aborts the sample; no mix_valid is produced for it.
- mix_valid is never high for two consecutive cycles.

Test Plan:
- Single voice, rounding:
  - Stimulus: voice0=16384, gain0=128, en=0x01, master=255, one lrck rise.
  - Response: mix_out=8160 (0x1FE0), mix_valid is one cycle in cycle 11 after the edge pulse, clip=0.
- Near unity:
  - Stimulus: voice0=32767, gain0=255, master=255, others disabled.
  - Response: mix_out=32511.
- Negative floor:
  - Stimulus: voice0=-1, gain0=1, master=1.
  - Response: mix_out=-1 (0xFFFF).
- Saturation:
  - Stimulus: all 8 voices=-32768, gains=255, en=0xFF, master=255.
  - Response: mix_out=-32768 (0x8000), clip=1.
  - Then assert flag_clr: clip=0.
  - Repeat with +32767: mix_out=32767.
- Enable and snapshot:
  - Stimulus: voice_en=0x00 with non-zero inputs.
  - Response: mix_out=0.
  - Stimulus: change voice0 from 100 to 5000 in cycle 2 after the edge, with gain0=255, master=255.
  - Response: result uses 100 (mix_out=99).
- Overrun and reset:
  - Stimulus: second lrck rise 4 cycles after the first.
  - Response: exactly one mix_valid, overrun=1.
  - Stimulus: Reset_n low during ACCUM.
  - Response: mix_out=0, busy=0, no mix_valid; the next edge produces a correct sample.

Source files
------------

// File: rtl/voice_mixer.sv
// voice_mixer
//   Sample-rate mixing stage between the voice bank and the codec data path.
//   A rising edge of the (asynchronous) DAC lrck snapshots every voice sample,
//   per-voice gain, enable and the master volume. The voices are then
//   multiply-accumulated serially, one per clock, scaled by master volume,
//   shifted back down by 2*GAIN_W (floor), saturated to SAMPLE_W and presented
//   on mix_out with a one-cycle mix_valid strobe.
//
// Ports
//   Clk, Reset_n  : system clock, asynchronous active-low reset
//   lrck          : DAC left/right clock, asynchronous to Clk
//   voice_in      : NUM_VOICES signed samples, voice i at [i*SAMPLE_W +: SAMPLE_W]
//   voice_gain    : NUM_VOICES unsigned gains, voice i at [i*GAIN_W +: GAIN_W]
//   voice_en      : per-voice enable; a disabled voice contributes 0
//   master_vol    : unsigned master volume
//   flag_clr      : synchronous clear of clip/overrun (a same-cycle set wins)
//   mix_out       : signed mixed sample, held between updates
//   mix_valid     : one-cycle pulse when mix_out updates
//   busy          : high while a sample is being computed
//   clip          : sticky, an output sample saturated
//   overrun       : sticky, an lrck rise arrived while busy
module voice_mixer #(
    parameter int NUM_VOICES = 8,
    parameter int SAMPLE_W   = 16,
    parameter int GAIN_W     = 8
) (
    input  logic                           Clk,
    input  logic                           Reset_n,
    input  logic                           lrck,
    input  logic [NUM_VOICES*SAMPLE_W-1:0] voice_in,
    input  logic [NUM_VOICES*GAIN_W-1:0]   voice_gain,
    input  logic [NUM_VOICES-1:0]          voice_en,
    input  logic [GAIN_W-1:0]              master_vol,
    input  logic                           flag_clr,
    output logic [SAMPLE_W-1:0]            mix_out,
    output logic                           mix_valid,
    output logic                           busy,
    output logic                           clip,
    output logic                           overrun
);

    localparam int IDX_W  = $clog2(NUM_VOICES);
    localparam int PROD_W = SAMPLE_W + GAIN_W;
    localparam int ACC_W  = PROD_W + IDX_W;
    // Scaled product: accumulator times a zero-extended (GAIN_W+1)-bit volume.
    localparam int SCL_W  = ACC_W + GAIN_W + 1;

    localparam logic [IDX_W-1:0]        LAST_IDX = IDX_W'(NUM_VOICES - 1);
    localparam logic signed [SCL_W-1:0] S_MAX    = SCL_W'((1 << (SAMPLE_W - 1)) - 1);
    localparam logic signed [SCL_W-1:0] S_MIN    = -S_MAX - SCL_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        SCALE,
        OUT
    } state_t;

    state_t state;

    // lrck synchronizer and rise detect
    logic lrck_s1, lrck_s2, lrck_prev;
    logic lrck_rise;

    // Snapshot of the inputs taken on the capture cycle
    logic [SAMPLE_W-1:0] voice_sh [NUM_VOICES];
    logic [GAIN_W-1:0]   gain_sh  [NUM_VOICES];
    logic [NUM_VOICES-1:0] en_sh;
    logic [GAIN_W-1:0]   mvol_sh;

    logic [IDX_W-1:0]        idx;
    logic signed [ACC_W-1:0] acc;
    logic signed [SCL_W-1:0] prod;

    // Datapath terms
    logic signed [ACC_W-1:0]  voice_ext, gain_ext, mac_term;
    logic signed [SCL_W-1:0]  acc_ext, mvol_ext, shifted;
    logic [SAMPLE_W-1:0]      sat_val;
    logic                     sat_hit;

    assign lrck_rise = lrck_s2 & ~lrck_prev;

    // Operands are widened to the accumulator width before multiplying so the
    // product is formed signed at full precision (16x9 bits always fits).
    always_comb begin
        voice_ext = {{(ACC_W-SAMPLE_W){voice_sh[idx][SAMPLE_W-1]}}, voice_sh[idx]};
        gain_ext  = {{(ACC_W-GAIN_W){1'b0}}, gain_sh[idx]};
        mac_term  = '0;
        if (en_sh[idx]) begin
            mac_term = voice_ext * gain_ext;
        end
    end

    always_comb begin
        acc_ext  = {{(SCL_W-ACC_W){acc[ACC_W-1]}}, acc};
        mvol_ext = {{(SCL_W-GAIN_W){1'b0}}, mvol_sh};
    end

    // Arithmetic shift floors toward -inf; then clamp to the output range.
    always_comb begin
        shifted = prod >>> (2 * GAIN_W);
        sat_hit = 1'b0;
        sat_val = shifted[SAMPLE_W-1:0];
        if (shifted > S_MAX) begin
            sat_val = {1'b0, {(SAMPLE_W-1){1'b1}}};
            sat_hit = 1'b1;
        end else if (shifted < S_MIN) begin
            sat_val = {1'b1, {(SAMPLE_W-1){1'b0}}};
            sat_hit = 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= IDLE;
            lrck_s1   <= 1'b0;
            lrck_s2   <= 1'b0;
            lrck_prev <= 1'b0;
            for (int unsigned i = 0; i < NUM_VOICES; i++) begin
                voice_sh[i] <= '0;
                gain_sh[i]  <= '0;
            end
            en_sh     <= '0;
            mvol_sh   <= '0;
            idx       <= '0;
            acc       <= '0;
            prod      <= '0;
            mix_out   <= '0;
            mix_valid <= 1'b0;
            busy      <= 1'b0;
            clip      <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            lrck_s1   <= lrck;
            lrck_s2   <= lrck_s1;
            lrck_prev <= lrck_s2;
            mix_valid <= 1'b0;

            // Clear first so a set later in this block takes priority.
            if (flag_clr) begin
                clip    <= 1'b0;
                overrun <= 1'b0;
            end
            if (lrck_rise && (state != IDLE)) begin
                overrun <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (lrck_rise) begin
                        for (int unsigned i = 0; i < NUM_VOICES; i++) begin
                            voice_sh[i] <= voice_in[i*SAMPLE_W +: SAMPLE_W];
                            gain_sh[i]  <= voice_gain[i*GAIN_W +: GAIN_W];
                        end
                        en_sh   <= voice_en;
                        mvol_sh <= master_vol;
                        acc     <= '0;
                        idx     <= '0;
                        busy    <= 1'b1;
                        state   <= ACCUM;
                    end
                end
                ACCUM: begin
                    acc <= acc + mac_term;
                    idx <= idx + 1'b1;
                    if (idx == LAST_IDX) begin
                        state <= SCALE;
                    end
                end
                SCALE: begin
                    prod  <= acc_ext * mvol_ext;
                    state <= OUT;
                end
                OUT: begin
                    mix_out   <= sat_val;
                    mix_valid <= 1'b1;
                    if (sat_hit) begin
                        clip <= 1'b1;
                    end
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_voice_mixer.sv
// tb_voice_mixer
//   Directed and randomized stimulus for voice_mixer with an arithmetic
//   reference model of the mix (sum of enabled voice*gain, times master
//   volume, floor-divided by 2^(2*GAIN_W), clamped to 16-bit signed).
module tb_voice_mixer;

    localparam int NV = 8;
    localparam int SW = 16;
    localparam int GW = 8;

    logic              Clk = 1'b0;
    logic              Reset_n;
    logic              lrck;
    logic [NV*SW-1:0]  voice_in;
    logic [NV*GW-1:0]  voice_gain;
    logic [NV-1:0]     voice_en;
    logic [GW-1:0]     master_vol;
    logic              flag_clr;
    logic [SW-1:0]     mix_out;
    logic              mix_valid;
    logic              busy;
    logic              clip;
    logic              overrun;

    int errors = 0;
    int checks = 0;

    voice_mixer #(.NUM_VOICES(NV), .SAMPLE_W(SW), .GAIN_W(GW)) dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .lrck       (lrck),
        .voice_in   (voice_in),
        .voice_gain (voice_gain),
        .voice_en   (voice_en),
        .master_vol (master_vol),
        .flag_clr   (flag_clr),
        .mix_out    (mix_out),
        .mix_valid  (mix_valid),
        .busy       (busy),
        .clip       (clip),
        .overrun    (overrun)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic over the current input values.
    function automatic void model(output longint exp_s, output bit exp_clip);
        longint acc = 0;
        longint s;
        for (int i = 0; i < NV; i++) begin
            if (voice_en[i]) begin
                acc += longint'($signed(voice_in[i*SW +: SW])) *
                       longint'(voice_gain[i*GW +: GW]);
            end
        end
        acc = acc * longint'(master_vol);
        s = acc >>> (2 * GW);
        exp_clip = 1'b0;
        if (s > 32767) begin
            s = 32767;
            exp_clip = 1'b1;
        end else if (s < -32768) begin
            s = -32768;
            exp_clip = 1'b1;
        end
        exp_s = s;
    endfunction

    task automatic set_voice(input int i, input int v, input int g);
        voice_in[i*SW +: SW]   = SW'(v);
        voice_gain[i*GW +: GW] = GW'(g);
    endtask

    task automatic clear_inputs();
        voice_in   = '0;
        voice_gain = '0;
        voice_en   = '0;
        master_vol = '0;
    endtask

    task automatic pulse_clr();
        @(posedge Clk); #1;
        flag_clr = 1'b1;
        @(posedge Clk); #1;
        flag_clr = 1'b0;
    endtask

    // Raises lrck just after a clock edge (k=0) and observes 24 edges.
    // With a 2-FF synchronizer the internal rise pulse sits after edge 2
    // (cycle 0), so busy appears after edge 3 and mix_valid after edge 13.
    task automatic run_sample(input int chg_k, input logic [SW-1:0] chg_val,
                              input bit second_rise, output int n_valid,
                              output int first_k, output logic [SW-1:0] got,
                              output int busy_k);
        n_valid = 0;
        first_k = -1;
        busy_k  = -1;
        got     = '0;
        @(posedge Clk); #1;
        lrck = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            @(posedge Clk); #1;
            if (mix_valid) begin
                n_valid++;
                if (first_k < 0) begin
                    first_k = k;
                    got = mix_out;
                end
            end
            if (busy && busy_k < 0) busy_k = k;
            if (k == chg_k) voice_in[SW-1:0] = chg_val;
            if (second_rise) begin
                if (k == 2)  lrck = 1'b0;
                if (k == 4)  lrck = 1'b1;
                if (k == 16) lrck = 1'b0;
            end else if (k == 4) begin
                lrck = 1'b0;
            end
        end
    endtask

    initial begin
        int nv, fk, bk;
        logic [SW-1:0] got;
        longint exp_s;
        bit exp_clip;

        Reset_n  = 1'b0;
        lrck     = 1'b0;
        flag_clr = 1'b0;
        clear_inputs();
        repeat (3) @(posedge Clk);
        #1;
        check("rst_mix_out",   mix_out,   0);
        check("rst_mix_valid", mix_valid, 0);
        check("rst_busy",      busy,      0);
        check("rst_clip",      clip,      0);
        check("rst_overrun",   overrun,   0);
        Reset_n = 1'b1;
        repeat (3) @(posedge Clk);

        // Single voice with exact result and latency
        clear_inputs();
        set_voice(0, 16384, 128);
        voice_en = 8'h01;
        master_vol = 8'd255;
        run_sample(0, '0, 1'b0, nv, fk, got, bk);
        check("single_out",   $signed(got), 8160);
        check("single_nval",  nv, 1);
        check("single_lat",   fk, 13);
        check("single_busy",  bk, 3);
        check("single_clip",  clip, 0);
        check("single_idle",  busy, 0);

        // Near unity
        clear_inputs();
        set_voice(0, 32767, 255);
        voice_en = 8'h01;
        master_vol = 8'd255;
        run_sample(0, '0, 1'b0, nv, fk, got, bk);
        check("unity_out", $signed(got), 32511);

        // Negative result floors toward -inf
        clear_inputs();
        set_voice(0, -1, 1);
        voice_en = 8'h01;
        master_vol = 8'd1;
        run_sample(0, '0, 1'b0, nv, fk, got, bk);
        check("floor_out", $signed(got), -1);

        // Negative saturation, clear, positive saturation
        clear_inputs();
        for (int i = 0; i < NV; i++) set_voice(i, -32768, 255);
        voice_en = 8'hFF;
        master_vol = 8'd255;
        run_sample(0, '0, 1'b0, nv, fk, got, bk);
        check("satn_out",  $signed(got), -32768);
        check("satn_clip", clip, 1);
        pulse_clr();
        check("satn_clr",  clip, 0);
        for (int i = 0; i < NV; i++) set_voice(i, 32767, 255);
        run_sample(0, '0, 1'b0, nv, fk, got, bk);
        check("satp_out",  $signed(got), 32767);
        check("satp_clip", clip, 1);
        pulse_clr();

        // All voices disabled
        for (int i = 0; i < NV; i++) set_voice(i, 1000 + i, 200);
        voice_en = 8'h00;
        run_sample(0, '0, 1'b0, nv, fk, got, bk);
        check("dis_out", $signed(got), 0);

        // Snapshot: voice0 changes in cycle 2 after the rise
        clear_inputs();
        set_voice(0, 100, 255);
        voice_en = 8'h01;
        master_vol = 8'd255;
        run_sample(4, 16'd5000, 1'b0, nv, fk, got, bk);
        check("snap_out", $signed(got), 99);

        // Second rise while busy
        clear_inputs();
        set_voice(2, -1234, 77);
        set_voice(5, 4321, 200);
        voice_en = 8'h24;
        master_vol = 8'd180;
        model(exp_s, exp_clip);
        run_sample(0, '0, 1'b1, nv, fk, got, bk);
        check("ovr_nval",    nv, 1);
        check("ovr_flag",    overrun, 1);
        check("ovr_out",     $signed(got), exp_s);
        pulse_clr();
        check("ovr_clr",     overrun, 0);

        // Reset during ACCUM
        @(posedge Clk); #1;
        lrck = 1'b1;
        repeat (6) @(posedge Clk);
        #1;
        check("mid_busy_pre", busy, 1);
        Reset_n = 1'b0;
        lrck = 1'b0;
        #1;
        check("mid_rst_out",  $signed(mix_out), 0);
        check("mid_rst_busy", busy, 0);
        @(posedge Clk); #1;
        Reset_n = 1'b1;
        nv = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge Clk); #1;
            if (mix_valid) nv++;
        end
        check("mid_no_valid", nv, 0);
        model(exp_s, exp_clip);
        run_sample(0, '0, 1'b0, nv, fk, got, bk);
        check("post_rst_out",  $signed(got), exp_s);
        check("post_rst_nval", nv, 1);

        // Randomized mixes
        for (int t = 0; t < 24; t++) begin
            for (int i = 0; i < NV; i++) begin
                set_voice(i, int'($urandom_range(0, 65535)) - 32768,
                          int'($urandom_range(0, 255)));
            end
            voice_en = NV'($urandom);
            master_vol = GW'($urandom);
            pulse_clr();
            model(exp_s, exp_clip);
            run_sample(0, '0, 1'b0, nv, fk, got, bk);
            check("rnd_out",  $signed(got), exp_s);
            check("rnd_clip", clip, exp_clip);
            check("rnd_nval", nv, 1);
            check("rnd_ovr",  overrun, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
